// File: rtl/target_cmd_arbiter.sv
// Round-robin arbiter for the target-to-host command channel.
// Writes params and command, polls for ack, reads back the response.
module target_cmd_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int POLL_INTERVAL  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [16*NUM_REQ-1:0]    req_cmd,
  input  logic [128*NUM_REQ-1:0]   req_param,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [15:0]              rsp_code,
  output logic [127:0]             rsp_data,
  output logic                     busy,
  output logic [7:0]               reg_addr,
  output logic                     reg_wr,
  output logic [31:0]              reg_wdata,
  output logic                     reg_rd,
  input  logic [31:0]              reg_rdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);
  localparam logic [31:0] PMAX = 32'(POLL_INTERVAL - 1);
  localparam logic [31:0] TLIM = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_PARAM,
    WR_CMD,
    WAIT,
    POLL_RD,
    POLL_CHK,
    RD_RSP,
    DONE
  } state_t;

  typedef struct packed {
    logic [15:0]  cmd;
    logic [127:0] param;
  } cmd_t;

  state_t      state, state_n;
  logic [IW-1:0] ptr, gnt, gidx;
  logic        any_req;
  cmd_t        cmd_q;
  logic [2:0]  cnt;
  logic [31:0] pcnt;
  logic [31:0] tcnt;
  logic        ack;
  logic        tout;
  logic [1:0]  widx;
  int          idx;

  assign ack  = (reg_rdata[31:16] == 16'h6F6B);
  assign tout = (tcnt >= TLIM);
  assign widx = 2'(cnt - 3'd1);

  // Round-robin search starting one past the last winner.
  always_comb begin
    any_req = 1'b0;
    gidx    = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        gidx    = IW'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Next-state and register-window strobes.
  always_comb begin
    state_n   = state;
    req_ready = '0;
    rsp_valid = '0;
    reg_addr  = 8'h00;
    reg_wr    = 1'b0;
    reg_wdata = 32'h0;
    reg_rd    = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (any_req && reset_n) begin
          req_ready[gidx] = 1'b1;
          busy            = 1'b1;
          state_n         = WR_PARAM;
        end
      end
      WR_PARAM: begin
        reg_wr    = 1'b1;
        reg_addr  = {4'h2, cnt[1:0], 2'b00};
        reg_wdata = cmd_q.param[cnt[1:0]*32 +: 32];
        if (cnt[1:0] == 2'd3) state_n = WR_CMD;
      end
      WR_CMD: begin
        reg_wr    = 1'b1;
        reg_wdata = {16'h636D, cmd_q.cmd};
        state_n   = WAIT;
      end
      WAIT: begin
        if (tout)              state_n = DONE;
        else if (pcnt == PMAX) state_n = POLL_RD;
      end
      POLL_RD: begin
        reg_rd  = 1'b1;
        state_n = tout ? DONE : POLL_CHK;
      end
      POLL_CHK: begin
        if (ack)       state_n = RD_RSP;
        else if (tout) state_n = DONE;
        else           state_n = WAIT;
      end
      RD_RSP: begin
        if (cnt < 3'd4) begin
          reg_rd   = 1'b1;
          reg_addr = {4'h4, cnt[1:0], 2'b00};
        end else begin
          state_n = DONE;
        end
      end
      DONE: begin
        rsp_valid[gnt] = 1'b1;
        state_n        = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Grant latch, counters and response capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= PTR_RST;
      gnt      <= '0;
      cmd_q    <= '0;
      cnt      <= '0;
      pcnt     <= '0;
      tcnt     <= '0;
      rsp_code <= '0;
      rsp_data <= '0;
    end else begin
      cnt  <= (state_n != state) ? 3'd0 : cnt + 3'd1;
      pcnt <= (state == WAIT && state_n == WAIT) ? pcnt + 32'd1 : 32'd0;
      if (state == WAIT || state == POLL_RD || state == POLL_CHK) begin
        if (tcnt != 32'hFFFF_FFFF) tcnt <= tcnt + 32'd1;
      end
      unique case (state)
        IDLE: begin
          if (any_req) begin
            ptr         <= gidx;
            gnt         <= gidx;
            cmd_q.cmd   <= req_cmd[gidx*16 +: 16];
            cmd_q.param <= req_param[gidx*128 +: 128];
          end
        end
        WR_CMD: tcnt <= '0;
        WAIT, POLL_RD: begin
          if (tout) begin
            rsp_code <= 16'hFFFF;
            rsp_data <= '0;
          end
        end
        POLL_CHK: begin
          if (ack) begin
            rsp_code <= reg_rdata[15:0];
          end else if (tout) begin
            rsp_code <= 16'hFFFF;
            rsp_data <= '0;
          end
        end
        RD_RSP: begin
          if (cnt != 3'd0) rsp_data[widx*32 +: 32] <= reg_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule
